// File: rtl/au_pkg.sv
// Shared types for the sequential arithmetic unit: op codes and FSM states.
package au_pkg;

  typedef enum logic [2:0] {
    OP_CNT  = 3'b000,
    OP_K    = 3'b001,
    OP_DATA = 3'b010,
    OP_R0   = 3'b011,
    OP_ADD  = 3'b100,
    OP_SUB  = 3'b101,
    OP_MUL  = 3'b110,
    OP_POW2 = 3'b111
  } op_t;

  typedef enum logic [1:0] {
    IDLE,
    EXEC,
    MUL,
    DONE
  } state_t;

  // Subtraction is the only op whose saturated result is the floor rather than the ceiling.
  function automatic logic sat_low(op_t op);
    return op == OP_SUB;
  endfunction

endpackage

// File: rtl/seq_mult.sv
// WIDTH-cycle shift-add multiplier: operands load on start, one multiplier bit per clock.
// done is asserted during the final step; product is the completed value in that cycle.
module seq_mult #(
  parameter int WIDTH = 5
) (
  input  logic                 clk,
  input  logic                 srst,
  input  logic                 start,
  input  logic [WIDTH-1:0]     a,
  input  logic [WIDTH-1:0]     b,
  output logic [2*WIDTH-1:0]   product,
  output logic                 done
);

  localparam int SW = $clog2(WIDTH + 1);

  logic [2*WIDTH-1:0] acc_reg;
  logic [2*WIDTH-1:0] mcand_reg;
  logic [WIDTH-1:0]   mplier_reg;
  logic [SW-1:0]      step_reg;
  logic               run_reg;
  logic [2*WIDTH-1:0] acc_next;

  always_comb begin
    acc_next = acc_reg;
    if (mplier_reg[0]) begin
      acc_next = acc_reg + mcand_reg;
    end
  end

  assign product = acc_next;
  assign done    = run_reg && (step_reg == SW'(WIDTH - 1));

  always_ff @(posedge clk) begin
    if (srst) begin
      acc_reg    <= '0;
      mcand_reg  <= '0;
      mplier_reg <= '0;
      step_reg   <= '0;
      run_reg    <= 1'b0;
    end else if (start) begin
      acc_reg    <= '0;
      mcand_reg  <= {{WIDTH{1'b0}}, a};
      mplier_reg <= b;
      step_reg   <= '0;
      run_reg    <= 1'b1;
    end else if (run_reg) begin
      acc_reg    <= acc_next;
      mcand_reg  <= mcand_reg << 1;
      mplier_reg <= mplier_reg >> 1;
      step_reg   <= step_reg + 1'b1;
      if (done) begin
        run_reg <= 1'b0;
      end
    end
  end

endmodule

// File: rtl/seq_au.sv
// Sequential arithmetic unit: one op per Start, registered result with a Done pulse.
// Define SEQ_AU_SATURATE_EN to clamp results on Overflow instead of wrapping.
module seq_au
  import au_pkg::*;
#(
  parameter int WIDTH = 5,
  parameter int CNT_W = 4,
  parameter int K_W   = 2
) (
  input  logic              Clock,
  input  logic              Reset,
  input  logic              Start,
  input  logic [2:0]        OP,
  input  logic [WIDTH-1:0]  DataIn,
  input  logic [WIDTH-1:0]  R0In,
  input  logic [K_W-1:0]    K,
  input  logic [CNT_W-1:0]  Counter,
  output logic [WIDTH-1:0]  DataOut,
  output logic              Busy,
  output logic              Done,
  output logic              Overflow
);

  // Wide enough to hold either the source or the result, so discarded bits can be inspected.
  localparam int CW = (CNT_W > WIDTH) ? CNT_W : WIDTH;
  localparam int KX = (K_W > WIDTH) ? K_W : WIDTH;

  state_t             state_reg;
  op_t                op_reg;
  logic [WIDTH-1:0]   a_reg;
  logic [WIDTH-1:0]   b_reg;
  logic [K_W-1:0]     k_reg;
  logic [CNT_W-1:0]   cnt_reg;
  logic [WIDTH-1:0]   data_out_reg;
  logic               busy_reg;
  logic               done_reg;
  logic               ovf_reg;

  logic [CW-1:0]      cnt_ext;
  logic [KX-1:0]      k_ext;
  logic [WIDTH:0]     sum;
  logic [WIDTH-1:0]   res_raw;
  logic [WIDTH-1:0]   res_next;
  logic               ovf_next;
  logic [2*WIDTH-1:0] product;
  logic               mul_done;
  logic               mul_start;

  assign mul_start = (state_reg == IDLE) && Start && (op_t'(OP) == OP_MUL);

  seq_mult #(.WIDTH(WIDTH)) u_mult (
    .clk     (Clock),
    .srst    (Reset),
    .start   (mul_start),
    .a       (R0In),
    .b       (DataIn),
    .product (product),
    .done    (mul_done)
  );

  assign cnt_ext = CW'(cnt_reg);
  assign k_ext   = KX'(k_reg);
  assign sum     = {1'b0, a_reg} + {1'b0, b_reg};

  always_comb begin
    res_raw  = '0;
    ovf_next = 1'b0;
    case (op_reg)
      OP_CNT: begin
        res_raw  = cnt_ext[WIDTH-1:0];
        ovf_next = |(cnt_ext >> WIDTH);
      end
      OP_K: begin
        res_raw  = k_ext[WIDTH-1:0];
        ovf_next = |(k_ext >> WIDTH);
      end
      OP_DATA: res_raw = b_reg;
      OP_R0:   res_raw = a_reg;
      OP_ADD: begin
        res_raw  = sum[WIDTH-1:0];
        ovf_next = sum[WIDTH];
      end
      OP_SUB: begin
        res_raw  = a_reg - b_reg;
        ovf_next = a_reg < b_reg;
      end
      OP_MUL: begin
        res_raw  = product[WIDTH-1:0];
        ovf_next = |product[2*WIDTH-1:WIDTH];
      end
      OP_POW2: begin
        if (32'(b_reg) >= WIDTH) begin
          res_raw  = '0;
          ovf_next = 1'b1;
        end else begin
          res_raw = WIDTH'(1) << b_reg;
        end
      end
      default: begin
        res_raw  = '0;
        ovf_next = 1'b0;
      end
    endcase
  end

`ifdef SEQ_AU_SATURATE_EN
  always_comb begin
    res_next = res_raw;
    if (ovf_next) begin
      res_next = sat_low(op_reg) ? '0 : '1;
    end
  end
`else
  assign res_next = res_raw;
`endif

  always_ff @(posedge Clock) begin
    if (Reset) begin
      state_reg    <= IDLE;
      op_reg       <= OP_CNT;
      a_reg        <= '0;
      b_reg        <= '0;
      k_reg        <= '0;
      cnt_reg      <= '0;
      data_out_reg <= '0;
      busy_reg     <= 1'b0;
      done_reg     <= 1'b0;
      ovf_reg      <= 1'b0;
    end else begin
      case (state_reg)
        IDLE: begin
          done_reg <= 1'b0;
          if (Start) begin
            op_reg    <= op_t'(OP);
            a_reg     <= R0In;
            b_reg     <= DataIn;
            k_reg     <= K;
            cnt_reg   <= Counter;
            busy_reg  <= 1'b1;
            state_reg <= (op_t'(OP) == OP_MUL) ? MUL : EXEC;
          end
        end
        EXEC: begin
          data_out_reg <= res_next;
          ovf_reg      <= ovf_next;
          done_reg     <= 1'b1;
          state_reg    <= DONE;
        end
        MUL: begin
          if (mul_done) begin
            data_out_reg <= res_next;
            ovf_reg      <= ovf_next;
            done_reg     <= 1'b1;
            state_reg    <= DONE;
          end
        end
        DONE: begin
          done_reg  <= 1'b0;
          busy_reg  <= 1'b0;
          state_reg <= IDLE;
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

  assign DataOut  = data_out_reg;
  assign Busy     = busy_reg;
  assign Done     = done_reg;
  assign Overflow = ovf_reg;

endmodule

// File: tb/tb_seq_au.sv
// Scoreboard bench for seq_au at WIDTH=5, CNT_W=4, K_W=2; honours SEQ_AU_SATURATE_EN.
module tb_seq_au;

  localparam int WIDTH = 5;
  localparam int CNT_W = 4;
  localparam int K_W   = 2;

  logic             clk = 1'b0;
  logic             reset;
  logic             start;
  logic [2:0]       op;
  logic [WIDTH-1:0] data_in;
  logic [WIDTH-1:0] r0_in;
  logic [K_W-1:0]   k;
  logic [CNT_W-1:0] counter;
  logic [WIDTH-1:0] data_out;
  logic             busy;
  logic             done;
  logic             overflow;

  typedef struct {
    logic [WIDTH-1:0] res;
    logic             ovf;
    int               lat;
  } exp_t;

  exp_t sb[$];
  int vectors = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  seq_au #(.WIDTH(WIDTH), .CNT_W(CNT_W), .K_W(K_W)) dut (
    .Clock    (clk),
    .Reset    (reset),
    .Start    (start),
    .OP       (op),
    .DataIn   (data_in),
    .R0In     (r0_in),
    .K        (k),
    .Counter  (counter),
    .DataOut  (data_out),
    .Busy     (busy),
    .Done     (done),
    .Overflow (overflow)
  );

  function automatic exp_t model(int o, int a, int b, int kk, int c);
    exp_t e;
    int v;
    v = 0;
    case (o)
      0: v = c;
      1: v = kk;
      2: v = b;
      3: v = a;
      4: v = a + b;
      5: v = a - b;
      6: v = a * b;
      default: v = (b >= WIDTH) ? (1 << WIDTH) : (1 << b);
    endcase
    e.res = WIDTH'(v);
    e.ovf = (o == 5) ? (a < b) : (v > (1 << WIDTH) - 1);
`ifdef SEQ_AU_SATURATE_EN
    if (e.ovf) e.res = (o == 5) ? '0 : '1;
`endif
    e.lat = (o == 6) ? WIDTH + 1 : 2;
    return e;
  endfunction

  // Drives one request from IDLE; returns #1 after the accept edge (cycle 1).
  task automatic issue(int o, int a, int b, int kk, int c);
    op      = 3'(o);
    r0_in   = WIDTH'(a);
    data_in = WIDTH'(b);
    k       = K_W'(kk);
    counter = CNT_W'(c);
    start   = 1'b1;
    sb.push_back(model(o, a, b, kk, c));
    @(posedge clk); #1;
    start   = 1'b0;
    r0_in   = WIDTH'($urandom);
    data_in = WIDTH'($urandom);
    k       = K_W'($urandom);
    counter = CNT_W'($urandom);
  endtask

  task automatic wait_done(input int from, output int lat, output bit bok);
    lat = from;
    bok = 1'b1;
    while (done !== 1'b1 && lat < 40) begin
      if (busy !== 1'b1) bok = 1'b0;
      @(posedge clk); #1;
      lat++;
    end
    if (busy !== 1'b1) bok = 1'b0;
  endtask

  task automatic test_reset;
    reset = 1'b1; start = 1'b1; op = 3'd4;
    r0_in = 5'd1; data_in = 5'd1; k = '0; counter = '0;
    repeat (3) @(posedge clk);
    #1;
    vectors++; if (busy !== 1'b0) begin miscompares++; $display("FAIL reset busy: got %b want 0", busy); end
    vectors++; if (done !== 1'b0) begin miscompares++; $display("FAIL reset done: got %b want 0", done); end
    vectors++; if (data_out !== '0) begin miscompares++; $display("FAIL reset data_out: got %0d want 0", data_out); end
    vectors++; if (overflow !== 1'b0) begin miscompares++; $display("FAIL reset overflow: got %b want 0", overflow); end
    reset = 1'b0; start = 1'b0;
    @(posedge clk); #1;
    $display("reset: busy=%b done=%b data_out=%0d overflow=%b", busy, done, data_out, overflow);
  endtask

  task automatic test_single_ops;
    int t_op[11] = '{4, 4, 5, 7, 7, 0, 1, 2, 3, 5, 7};
    int t_a[11]  = '{12, 20, 3, 0, 0, 0, 0, 0, 17, 9, 0};
    int t_b[11]  = '{7, 15, 5, 4, 6, 0, 0, 21, 0, 9, 5};
    int t_k[11]  = '{0, 0, 0, 0, 0, 0, 3, 0, 0, 0, 0};
    int t_c[11]  = '{0, 0, 0, 0, 0, 9, 0, 0, 0, 0, 0};
    exp_t e;
    int lat;
    bit bok;
    for (int i = 0; i < 11; i++) begin
      issue(t_op[i], t_a[i], t_b[i], t_k[i], t_c[i]);
      wait_done(1, lat, bok);
      e = sb.pop_front();
      $display("single[%0d] op=%0d a=%0d b=%0d: data_out=%0d ovf=%b lat=%0d", i, t_op[i], t_a[i], t_b[i], data_out, overflow, lat);
      vectors++; if (lat !== e.lat) begin miscompares++; $display("FAIL single[%0d] latency: got %0d want %0d", i, lat, e.lat); end
      vectors++; if (data_out !== e.res) begin miscompares++; $display("FAIL single[%0d] data_out: got %0d want %0d", i, data_out, e.res); end
      vectors++; if (overflow !== e.ovf) begin miscompares++; $display("FAIL single[%0d] overflow: got %b want %b", i, overflow, e.ovf); end
      vectors++; if (bok !== 1'b1) begin miscompares++; $display("FAIL single[%0d] busy: got %b want 1", i, bok); end
      @(posedge clk); #1;
      vectors++;
      if (busy !== 1'b0 || done !== 1'b0 || data_out !== e.res) begin
        miscompares++;
        $display("FAIL single[%0d] idle hold: got busy=%b done=%b data_out=%0d want 0 0 %0d", i, busy, done, data_out, e.res);
      end
    end
  endtask

  task automatic test_back_to_back;
    exp_t e;
    int lat;
    bit bok;
    issue(4, 1, 2, 0, 0);
    wait_done(1, lat, bok);
    e = sb.pop_front();
    vectors++; if (data_out !== e.res) begin miscompares++; $display("FAIL b2b first data_out: got %0d want %0d", data_out, e.res); end
    // Start raised in the DONE cycle must not be taken until IDLE.
    start = 1'b1; op = 3'd5; r0_in = 5'd10; data_in = 5'd4;
    @(posedge clk); #1;
    vectors++; if (busy !== 1'b0) begin miscompares++; $display("FAIL b2b start in done: got busy=%b want 0", busy); end
    issue(5, 10, 4, 0, 0);
    vectors++; if (data_out !== e.res) begin miscompares++; $display("FAIL b2b data_out hold: got %0d want %0d", data_out, e.res); end
    wait_done(1, lat, bok);
    e = sb.pop_front();
    $display("b2b op=5 a=10 b=4: data_out=%0d ovf=%b lat=%0d", data_out, overflow, lat);
    vectors++; if (lat !== e.lat) begin miscompares++; $display("FAIL b2b latency: got %0d want %0d", lat, e.lat); end
    vectors++; if (data_out !== e.res || overflow !== e.ovf) begin miscompares++; $display("FAIL b2b result: got %0d/%b want %0d/%b", data_out, overflow, e.res, e.ovf); end
    @(posedge clk); #1;
  endtask

  task automatic test_mul;
    int t_a[4] = '{6, 7, 0, 31};
    int t_b[4] = '{5, 5, 9, 31};
    exp_t e;
    int lat;
    bit bok;
    bit extra;
    for (int i = 0; i < 4; i++) begin
      issue(6, t_a[i], t_b[i], 0, 0);
      if (i == 0) begin
        start = 1'b1; op = 3'd4; r0_in = 5'd1; data_in = 5'd1;
        @(posedge clk); #1;
        start = 1'b0;
        wait_done(2, lat, bok);
      end else begin
        wait_done(1, lat, bok);
      end
      e = sb.pop_front();
      $display("mul[%0d] a=%0d b=%0d: data_out=%0d ovf=%b lat=%0d", i, t_a[i], t_b[i], data_out, overflow, lat);
      vectors++; if (lat !== e.lat) begin miscompares++; $display("FAIL mul[%0d] latency: got %0d want %0d", i, lat, e.lat); end
      vectors++; if (data_out !== e.res) begin miscompares++; $display("FAIL mul[%0d] data_out: got %0d want %0d", i, data_out, e.res); end
      vectors++; if (overflow !== e.ovf) begin miscompares++; $display("FAIL mul[%0d] overflow: got %b want %b", i, overflow, e.ovf); end
      vectors++; if (bok !== 1'b1) begin miscompares++; $display("FAIL mul[%0d] busy: got %b want 1", i, bok); end
      extra = 1'b0;
      repeat (8) begin
        @(posedge clk); #1;
        if (done === 1'b1 || busy === 1'b1) extra = 1'b1;
      end
      vectors++; if (extra !== 1'b0) begin miscompares++; $display("FAIL mul[%0d] ignored start: got extra activity=%b want 0", i, extra); end
    end
  endtask

  task automatic test_reset_mid_mul;
    exp_t e;
    int lat;
    bit bok;
    bit extra;
    issue(6, 6, 5, 0, 0);
    e = sb.pop_back();
    @(posedge clk); #1;
    @(posedge clk); #1;
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    $display("reset mid-mul: busy=%b done=%b data_out=%0d ovf=%b", busy, done, data_out, overflow);
    vectors++; if (busy !== 1'b0) begin miscompares++; $display("FAIL midmul busy: got %b want 0", busy); end
    vectors++; if (data_out !== '0) begin miscompares++; $display("FAIL midmul data_out: got %0d want 0", data_out); end
    vectors++; if (overflow !== 1'b0 || done !== 1'b0) begin miscompares++; $display("FAIL midmul flags: got ovf=%b done=%b want 0 0", overflow, done); end
    extra = 1'b0;
    repeat (8) begin
      @(posedge clk); #1;
      if (done === 1'b1) extra = 1'b1;
    end
    vectors++; if (extra !== 1'b0) begin miscompares++; $display("FAIL midmul stray done: got %b want 0", extra); end
    issue(6, 3, 3, 0, 0);
    wait_done(1, lat, bok);
    e = sb.pop_front();
    $display("post-reset mul a=3 b=3: data_out=%0d ovf=%b lat=%0d", data_out, overflow, lat);
    vectors++; if (lat !== e.lat) begin miscompares++; $display("FAIL midmul fresh latency: got %0d want %0d", lat, e.lat); end
    vectors++; if (data_out !== e.res || overflow !== e.ovf) begin miscompares++; $display("FAIL midmul fresh result: got %0d/%b want %0d/%b", data_out, overflow, e.res, e.ovf); end
    @(posedge clk); #1;
  endtask

  initial begin
    test_reset();
    test_single_ops();
    test_back_to_back();
    test_mul();
    test_reset_mid_mul();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
